imem_loader: RTL

Streaming writer for the multi-cycle processor's 256×32 instruction memory. It takes a byte stream (valid/ready) carrying a 16-bit word count and then that many 32-bit instructions, most significant byte first. It assembles each instruction, writes it to consecutive word addresses starting at 0, and holds the processor stalled until the image is complete. It is the write-side counterpart to the instruction-fetch read port. It lets hardware load a program instead of `$readmemb` at elaboration.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Used by the loader FSM, the byte packer and the bus interface.
package imem_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    // States in which a new load may be started.
    function automatic logic can_start(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status.
// master = stream source / controller side, slave = the loader.
interface imem_loader_if #(
    parameter int ADDR_W = imem_pkg::IMEM_ADDR_W
) ();
    logic                         start;
    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [imem_pkg::INSTR_W-1:0] mem_wdata;
    logic                         cpu_hold;
    logic                         done;
    logic                         error;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes, MSB first, into one instruction word.
// o_word_ready flags the accept that completes the word.
module byte_packer
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_accept,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_word_ready
);
    logic [INSTR_W-1:0] r_word;
    logic [1:0]         r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_accept) begin
            r_word <= {r_word[INSTR_W-9:0], i_byte};
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_accept && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed instruction image from a byte stream into the
// instruction memory, holding the CPU stalled until the image is complete.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    state_t            r_state;
    logic              r_in_ready;
    logic              r_cpu_hold;
    logic              r_mem_we;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_count;
    logic [15:0]       r_wcnt;

    logic               w_accept;
    logic               w_restart;
    logic [15:0]        w_len;
    logic [15:0]        w_wcnt_inc;
    logic [INSTR_W-1:0] w_word;
    logic               w_word_ready;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_restart  = bus.start && can_start(r_state);
    assign w_len      = {r_count[15:8], bus.in_data};
    assign w_wcnt_inc = r_wcnt + 16'd1;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_restart),
        .i_accept     (w_accept && (r_state == S_DATA)),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_wcnt     <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_restart) begin
                        r_state    <= S_LEN_HI;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_addr     <= '0;
                        r_count    <= '0;
                        r_wcnt     <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= bus.in_data;
                        r_state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= bus.in_data;
                        if (w_len == 16'd0) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                        end else if (w_len > 16'(DEPTH)) begin
                            r_state    <= S_ERROR;
                            r_error    <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_ready) begin
                        r_state    <= S_WRITE;
                        r_in_ready <= 1'b0;
                        r_mem_we   <= 1'b1;
                    end
                end
                S_WRITE: begin
                    // Address is one past the last write after the final word.
                    r_addr <= r_addr + 1'b1;
                    r_wcnt <= w_wcnt_inc;
                    if (w_wcnt_inc == r_count) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state    <= S_DATA;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_word;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

endmodule
